// File: rtl/data_memory.sv
// Single-port synchronous data RAM with a registered, write-through read port.
// The whole array and the read register clear asynchronously when rst_n is low.
module data_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  w,
  input  logic                  r,
  output logic [DATA_WIDTH-1:0] dataout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dataout_d;
  logic [DATA_WIDTH-1:0] dataout_q;

  // Next read value: a simultaneous write forwards datain instead of the stale word.
  always_comb begin
    dataout_d = dataout_q;
    if (r) begin
      if (w) begin
        dataout_d = datain;
      end else begin
        dataout_d = mem_q[adr];
      end
    end else begin
      dataout_d = dataout_q;
    end
  end

  // Memory array: cleared on reset so no location ever reads X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w) begin
      mem_q[adr] <= datain;
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout_q <= '0;
    end else begin
      dataout_q <= dataout_d;
    end
  end

  assign dataout = dataout_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory with hand-written reset sequences.
module tb_data_memory;

  logic       clk;
  logic       rst_n;
  logic [7:0] adr;
  logic [7:0] datain;
  logic       w;
  logic       r;
  logic [7:0] dataout;

  int n_vec;
  int n_bad;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] adr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [19];

  data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .adr     (adr),
    .datain  (datain),
    .w       (w),
    .r       (r),
    .dataout (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] exp);
    n_vec++;
    if (dataout !== exp) begin
      n_bad++;
      $display("FAIL %s: dataout=%02h expected=%02h", name, dataout, exp);
    end
  endtask

  // Drive one access, let one rising edge sample it, then compare.
  task automatic apply(input string name, input logic wi, input logic ri,
                       input logic [7:0] ai, input logic [7:0] di, input logic [7:0] exp);
    w = wi;
    r = ri;
    adr = ai;
    datain = di;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    w = 1'b0;
    r = 1'b0;
    adr = 8'h00;
    datain = 8'h00;

    //            w     r     adr    din    exp
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h0A, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF};
    vecs[4]  = '{1'b1, 1'b0, 8'h0A, 8'h55, 8'hFF};
    vecs[5]  = '{1'b0, 1'b1, 8'h0A, 8'h00, 8'h55};
    vecs[6]  = '{1'b1, 1'b1, 8'h0A, 8'h5A, 8'h5A};
    vecs[7]  = '{1'b0, 1'b1, 8'h0A, 8'h00, 8'h5A};
    vecs[8]  = '{1'b1, 1'b0, 8'h10, 8'hA5, 8'h5A};
    vecs[9]  = '{1'b0, 1'b1, 8'h10, 8'h00, 8'hA5};
    vecs[10] = '{1'b1, 1'b0, 8'h11, 8'h3C, 8'hA5};
    vecs[11] = '{1'b0, 1'b1, 8'h11, 8'h00, 8'h3C};
    vecs[12] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'hA5};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 8'h01, 8'hA5};
    vecs[14] = '{1'b1, 1'b0, 8'hFF, 8'h80, 8'hA5};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01};
    vecs[16] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h80};
    vecs[17] = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'h00};
    vecs[18] = '{1'b0, 1'b0, 8'hFF, 8'h99, 8'h00};

    #3;
    check("reset_initial", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].w, vecs[i].r, vecs[i].adr, vecs[i].din, vecs[i].exp);
    end

    // Inputs changed between edges with r=0 must not disturb the output.
    w = 1'b0;
    r = 1'b0;
    adr = 8'h10;
    #2;
    adr = 8'hFF;
    @(posedge clk);
    #1;
    check("hold_between_edges", 8'h00);

    // Mid-run reset: asynchronous clear, and an edge during reset performs no write.
    apply("fill_0a", 1'b1, 1'b0, 8'h0A, 8'h55, 8'h00);
    apply("read_0a", 1'b0, 1'b1, 8'h0A, 8'h00, 8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 8'h00);
    w = 1'b1;
    r = 1'b1;
    adr = 8'h20;
    datain = 8'h77;
    @(posedge clk);
    #1;
    check("edge_in_reset", 8'h00);
    @(negedge clk);
    w = 1'b0;
    r = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    apply("post_rst_0a", 1'b0, 1'b1, 8'h0A, 8'h00, 8'h00);
    apply("post_rst_20", 1'b0, 1'b1, 8'h20, 8'h00, 8'h00);
    apply("post_rst_ff", 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00);
    apply("wt_after_rst", 1'b1, 1'b1, 8'h33, 8'hC3, 8'hC3);
    apply("read_33", 1'b0, 1'b1, 8'h33, 8'h00, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
